// File: rtl/cpu_run_dump_ctrl.sv
// Run controller and end-of-run state dump for the 16-bit pipelined CPU.
// Latency: fetch, capture, then entry offered on the third cycle; min 3 cycles per emitted entry.
// Backpressure: dump_valid and payload hold until dump_ready; next fetch starts on the transfer edge.
module cpu_run_dump_ctrl #(
  parameter int                 INSTR_W      = 16,
  parameter int                 DATA_W       = 16,
  parameter int                 ADDR_W       = 16,
  parameter int                 MEM_WORDS    = 2**ADDR_W,
  parameter int                 NREGS        = 16,
  parameter int                 RESET_CYCLES = 4,
  parameter int                 DRAIN_CYCLES = 10,
  parameter logic [INSTR_W-1:0] HALT_OP0     = 16'hE000,
  parameter logic [INSTR_W-1:0] HALT_OP1     = 16'hE7FF,
  parameter int                 MAX_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     cpu_reset,
  input  logic [INSTR_W-1:0]       instr,
  output logic [$clog2(NREGS)-1:0] reg_addr,
  input  logic [DATA_W-1:0]        reg_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic                     dump_kind,
  output logic [ADDR_W-1:0]        dump_index,
  output logic [DATA_W-1:0]        dump_data,
  output logic [31:0]              cycle_count,
  output logic                     timeout,
  output logic                     done
);

  localparam int RA_W = $clog2(NREGS);

  typedef enum logic [2:0] {
    IDLE, RESET_HOLD, RUN, DRAIN, DUMP_REG, DUMP_MEM, DONE
  } state_t;

  // Sub-step of each dump entry: address presented, read data captured, entry offered.
  typedef enum logic [1:0] {
    PH_FETCH, PH_CAP, PH_OUT
  } phase_t;

  state_t      state;
  phase_t      phase;
  logic [31:0] hold_cnt;   // shared by the reset-hold and drain windows
  logic        is_halt;
  logic        reg_last;
  logic        mem_last;

  assign is_halt  = (instr == HALT_OP0) || (instr == HALT_OP1);
  assign reg_last = (reg_addr == RA_W'(NREGS - 1));
  assign mem_last = (mem_addr == ADDR_W'(MEM_WORDS - 1));

  // Controller: state, phase and every output are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= PH_FETCH;
      hold_cnt    <= '0;
      cpu_reset   <= 1'b1;
      reg_addr    <= '0;
      mem_addr    <= '0;
      dump_valid  <= 1'b0;
      dump_kind   <= 1'b0;
      dump_index  <= '0;
      dump_data   <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A new run starts from a clean slate whether coming from IDLE or a finished dump.
          if (start) begin
            state       <= RESET_HOLD;
            phase       <= PH_FETCH;
            hold_cnt    <= '0;
            cpu_reset   <= 1'b1;
            reg_addr    <= '0;
            mem_addr    <= '0;
            dump_valid  <= 1'b0;
            dump_kind   <= 1'b0;
            dump_index  <= '0;
            dump_data   <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            done        <= 1'b0;
          end
        end

        RESET_HOLD: begin
          if (hold_cnt + 32'd1 >= 32'(RESET_CYCLES)) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end

        RUN: begin
          // Halt wins over timeout; neither the halt nor the timeout cycle is counted.
          if (is_halt) begin
            state    <= DRAIN;
            hold_cnt <= '0;
          end else if ((MAX_CYCLES != 0) && (cycle_count == 32'(MAX_CYCLES))) begin
            state    <= DRAIN;
            hold_cnt <= '0;
            timeout  <= 1'b1;
          end else begin
            cycle_count <= cycle_count + 32'd1;
          end
        end

        DRAIN: begin
          if (hold_cnt + 32'd1 >= 32'(DRAIN_CYCLES)) begin
            state    <= DUMP_REG;
            phase    <= PH_FETCH;
            reg_addr <= '0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end

        DUMP_REG: begin
          case (phase)
            PH_FETCH: phase <= PH_CAP;
            PH_CAP: begin
              dump_valid <= 1'b1;
              dump_kind  <= 1'b0;
              dump_index <= ADDR_W'(reg_addr);
              dump_data  <= reg_rdata;
              phase      <= PH_OUT;
            end
            PH_OUT: begin
              if (dump_ready) begin
                dump_valid <= 1'b0;
                phase      <= PH_FETCH;
                if (reg_last) begin
                  state    <= DUMP_MEM;
                  mem_addr <= '0;
                end else begin
                  reg_addr <= reg_addr + 1'b1;
                end
              end
            end
            default: phase <= PH_FETCH;
          endcase
        end

        DUMP_MEM: begin
          case (phase)
            PH_FETCH: phase <= PH_CAP;
            PH_CAP: begin
              if (mem_rdata != '0) begin
                dump_valid <= 1'b1;
                dump_kind  <= 1'b1;
                dump_index <= mem_addr;
                dump_data  <= mem_rdata;
                phase      <= PH_OUT;
              end else begin
                // Zero word: no entry, go straight to the next address.
                phase <= PH_FETCH;
                if (mem_last) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  mem_addr <= mem_addr + 1'b1;
                end
              end
            end
            PH_OUT: begin
              if (dump_ready) begin
                dump_valid <= 1'b0;
                phase      <= PH_FETCH;
                if (mem_last) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  mem_addr <= mem_addr + 1'b1;
                end
              end
            end
            default: phase <= PH_FETCH;
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
